vm_input_conditioner: RTL and testbench

Front-end conditioner that sits directly upstream of the vending machine core. It synchronises and debounces the nine selection buttons, six coin inputs and the coins-display button. Selection and coin presses are converted into clean single-cycle, one-hot pulses. The coins-display button is delivered as a debounced level, because the core acts on both of its edges.

---
 rtl/vm_input_conditioner.sv | 123 ++++++++++++
 tb/tb_vm_input_conditioner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vm_input_conditioner.sv
// vm_input_conditioner: synchronises and debounces the selection, coin and
// coins-display inputs, then turns selection/coin presses into arbitrated
// single-cycle one-hot pulses. Coins beat selections; a beaten selection is
// parked in a one-entry pending register and issues on a later cycle.
module vm_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       cancelReset,
  input  logic [8:0] sel_raw,
  input  logic [5:0] coin_raw,
  input  logic       coins_disp_raw,
  output logic [8:0] sel_pulse,
  output logic [5:0] coin_pulse,
  output logic       coins_disp,
  output logic       collision
);

  localparam int unsigned N_IN = 16;
  localparam int unsigned N_EV = 15;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {EMPTY, HELD} pend_t;

  logic [N_IN-1:0]  raw;
  logic [N_IN-1:0]  sync1;
  logic [N_IN-1:0]  sync2;
  logic [N_IN-1:0]  stable;
  logic [N_EV-1:0]  stable_d;
  logic [CNT_W-1:0] cnt [N_IN];

  logic [N_EV-1:0] cand;
  logic [8:0]      sel_cand;
  logic [5:0]      coin_cand;
  logic [8:0]      sel_win;
  logic [5:0]      coin_win;
  logic            sel_any;
  logic            coin_any;
  logic            sel_coll;
  logic            coin_coll;

  pend_t      pend_state;
  logic [8:0] pend_sel;

  assign raw = {coins_disp_raw, coin_raw, sel_raw};

  // Two-flop synchronisers plus per-input debounce counters
  always_ff @(posedge clk or posedge cancelReset) begin
    if (cancelReset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < N_IN; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_d <= stable[N_EV-1:0];
      for (int i = 0; i < N_IN; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= ~stable[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Rising edges of the debounced levels and lowest-index arbitration per group
  always_comb begin
    cand      = stable[N_EV-1:0] & ~stable_d;
    sel_cand  = cand[8:0];
    coin_cand = cand[14:9];
    sel_win   = sel_cand & (~sel_cand + 9'd1);
    coin_win  = coin_cand & (~coin_cand + 6'd1);
    sel_any   = |sel_cand;
    coin_any  = |coin_cand;
    sel_coll  = |(sel_cand & (sel_cand - 9'd1));
    coin_coll = |(coin_cand & (coin_cand - 6'd1));
  end

  // Output pulses and the pending-selection register; coins always go first
  always_ff @(posedge clk or posedge cancelReset) begin
    if (cancelReset) begin
      sel_pulse  <= '0;
      coin_pulse <= '0;
      coins_disp <= 1'b0;
      collision  <= 1'b0;
      pend_state <= EMPTY;
      pend_sel   <= '0;
    end else begin
      sel_pulse  <= '0;
      coin_pulse <= '0;
      coins_disp <= stable[N_IN-1];
      // a selection that finds the pending slot occupied behind a coin is lost
      collision  <= sel_coll | coin_coll | (coin_any & sel_any & (pend_state == HELD));
      if (coin_any) begin
        coin_pulse <= coin_win;
        if ((pend_state == EMPTY) && sel_any) begin
          pend_state <= HELD;
          pend_sel   <= sel_win;
        end
      end else if (pend_state == HELD) begin
        sel_pulse <= pend_sel;
        if (sel_any) begin
          pend_sel <= sel_win;
        end else begin
          pend_state <= EMPTY;
          pend_sel   <= '0;
        end
      end else begin
        sel_pulse <= sel_win;
      end
    end
  end

endmodule

// File: tb/tb_vm_input_conditioner.sv
// Bench for vm_input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios
// plus randomized presses and glitches, checked by a cycle-stamped scoreboard.
module tb_vm_input_conditioner;

  localparam int unsigned DC  = 4;
  localparam int          LAT = DC + 3;  // drive just after edge c -> pulse after edge c+LAT

  logic       clk = 1'b0;
  logic       cancelReset;
  logic [8:0] sel_raw;
  logic [5:0] coin_raw;
  logic       coins_disp_raw;
  logic [8:0] sel_pulse;
  logic [5:0] coin_pulse;
  logic       coins_disp;
  logic       collision;

  typedef struct {
    int         cyc;
    logic [8:0] sel;
    logic [5:0] coin;
    logic       coll;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   disp_on  = 0;
  int   disp_off = 0;

  vm_input_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk            (clk),
    .cancelReset    (cancelReset),
    .sel_raw        (sel_raw),
    .coin_raw       (coin_raw),
    .coins_disp_raw (coins_disp_raw),
    .sel_pulse      (sel_pulse),
    .coin_pulse     (coin_pulse),
    .coins_disp     (coins_disp),
    .collision      (collision)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: level check of coins_disp, scoreboard pop on any pulse, miss detection
  always @(negedge clk) begin
    exp_t e;
    logic exp_d;
    if (cancelReset === 1'b1) begin
      tests++;
      if (sel_pulse !== '0 || coin_pulse !== '0 || coins_disp !== 1'b0 || collision !== 1'b0) begin
        fails++;
        $display("FAIL reset_zero cyc=%0d sel=%h coin=%h disp=%b coll=%b, required all 0",
                 cyc, sel_pulse, coin_pulse, coins_disp, collision);
      end
    end else begin
      exp_d = (cyc >= disp_on) && (cyc < disp_off);
      tests++;
      if (coins_disp !== exp_d) begin
        fails++;
        $display("FAIL coins_disp cyc=%0d got %b required %b", cyc, coins_disp, exp_d);
      end
      if (sel_pulse !== '0 || coin_pulse !== '0 || collision !== 1'b0) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_pulse cyc=%0d sel=%h coin=%h coll=%b, required none",
                   cyc, sel_pulse, coin_pulse, collision);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.sel !== sel_pulse || e.coin !== coin_pulse || e.coll !== collision) begin
            fails++;
            $display("FAIL pulse cyc=%0d sel=%h coin=%h coll=%b, required cyc=%0d sel=%h coin=%h coll=%b",
                     cyc, sel_pulse, coin_pulse, collision, e.cyc, e.sel, e.coin, e.coll);
          end
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        tests++;
        fails++;
        e = q.pop_front();
        $display("FAIL missed_pulse cyc=%0d nothing seen, required cyc=%0d sel=%h coin=%h coll=%b",
                 cyc, e.cyc, e.sel, e.coin, e.coll);
      end
    end
  end

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++) if (m[i]) return i;
    return -1;
  endfunction

  function automatic int popcnt(input logic [15:0] m);
    int n = 0;
    for (int i = 0; i < 16; i++) if (m[i]) n++;
    return n;
  endfunction

  // Reference: expected pulses for a set of presses all starting after edge c
  task automatic expect_presses(input int c, input logic [8:0] s, input logic [5:0] k);
    exp_t e;
    logic [15:0] sw, kw;
    logic        coll;
    sw   = 16'(s);
    kw   = 16'(k);
    coll = (popcnt(sw) > 1) || (popcnt(kw) > 1);
    if (k != 0) begin
      e.cyc = c + LAT; e.sel = '0; e.coin = 6'(1 << lowest(kw)); e.coll = coll;
      q.push_back(e);
      if (s != 0) begin
        e.cyc = c + LAT + 1; e.sel = 9'(1 << lowest(sw)); e.coin = '0; e.coll = 1'b0;
        q.push_back(e);
      end
    end else if (s != 0) begin
      e.cyc = c + LAT; e.sel = 9'(1 << lowest(sw)); e.coin = '0; e.coll = coll;
      q.push_back(e);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press a set of inputs together, hold, release, and let things settle
  task automatic press(input logic [8:0] s, input logic [5:0] k, input int hold);
    tick(1);
    expect_presses(cyc, s, k);
    sel_raw  = s;
    coin_raw = k;
    tick(hold);
    sel_raw  = '0;
    coin_raw = '0;
    tick(12);
  endtask

  initial begin
    exp_t e;
    int   c;
    cancelReset    = 1'b1;
    sel_raw        = '0;
    coin_raw       = '0;
    coins_disp_raw = 1'b0;
    tick(3);
    cancelReset = 1'b0;
    tick(4);

    // clean coin press
    press(9'h000, 6'b000100, 20);

    // bounce rejection on A1, then a clean final rise
    tick(1);
    for (int i = 0; i < 4; i++) begin
      sel_raw[0] = 1'b1; tick(2);
      sel_raw[0] = 1'b0; tick(2);
    end
    expect_presses(cyc, 9'h001, 6'h00);
    sel_raw[0] = 1'b1;
    tick(20);
    sel_raw[0] = 1'b0;
    tick(12);

    // group collision and cross-group ordering
    press(9'h088, 6'h00, 12);
    press(9'h100, 6'b010000, 12);

    // coins-display level follows with the same latency on both edges
    tick(1);
    disp_on  = cyc + LAT;
    disp_off = cyc + LAT + 10;
    coins_disp_raw = 1'b1;
    tick(10);
    coins_disp_raw = 1'b0;
    tick(14);

    // pending selection issues first, the newer one is held one more cycle
    tick(1);
    c = cyc;
    coin_raw = 6'h02; sel_raw = 9'h004;
    tick(1);
    sel_raw = 9'h024;
    e.cyc = c + LAT;     e.sel = '0;     e.coin = 6'h02; e.coll = 1'b0; q.push_back(e);
    e.cyc = c + LAT + 1; e.sel = 9'h004; e.coin = '0;    e.coll = 1'b0; q.push_back(e);
    e.cyc = c + LAT + 2; e.sel = 9'h020; e.coin = '0;    e.coll = 1'b0; q.push_back(e);
    tick(12);
    sel_raw = '0; coin_raw = '0;
    tick(12);

    // a second coin keeps the pending selection waiting
    tick(1);
    c = cyc;
    coin_raw = 6'h01; sel_raw = 9'h001;
    tick(1);
    coin_raw = 6'h09;
    e.cyc = c + LAT;     e.sel = '0;     e.coin = 6'h01; e.coll = 1'b0; q.push_back(e);
    e.cyc = c + LAT + 1; e.sel = '0;     e.coin = 6'h08; e.coll = 1'b0; q.push_back(e);
    e.cyc = c + LAT + 2; e.sel = 9'h001; e.coin = '0;    e.coll = 1'b0; q.push_back(e);
    tick(12);
    sel_raw = '0; coin_raw = '0;
    tick(12);

    // reset mid-debounce with the coin still held: event lost, re-detected after release
    tick(1);
    coin_raw = 6'h01;
    tick(3);
    cancelReset = 1'b1;
    #1;
    tests++;
    if (sel_pulse !== '0 || coin_pulse !== '0 || coins_disp !== 1'b0 || collision !== 1'b0) begin
      fails++;
      $display("FAIL reset_async sel=%h coin=%h disp=%b coll=%b, required all 0",
               sel_pulse, coin_pulse, coins_disp, collision);
    end
    tick(2);
    cancelReset = 1'b0;
    expect_presses(cyc, 9'h000, 6'h01);
    tick(15);
    coin_raw = '0;
    tick(12);

    // randomized presses and sub-threshold glitches
    for (int n = 0; n < 40; n++) begin
      logic [8:0] s;
      logic [5:0] k;
      if ($urandom_range(0, 4) == 0) begin
        tick(1);
        if ($urandom_range(0, 1) == 0) sel_raw = 9'(1 << $urandom_range(0, 8));
        else                           coin_raw = 6'(1 << $urandom_range(0, 5));
        tick($urandom_range(1, DC - 1));
        sel_raw = '0; coin_raw = '0;
        tick(12);
      end else begin
        s = '0; k = '0;
        if ($urandom_range(0, 2) != 0) begin
          s = 9'(1 << $urandom_range(0, 8));
          if ($urandom_range(0, 2) == 0) s = s | 9'(1 << $urandom_range(0, 8));
        end
        if ($urandom_range(0, 2) != 0 || s == 0) begin
          k = 6'(1 << $urandom_range(0, 5));
          if ($urandom_range(0, 2) == 0) k = k | 6'(1 << $urandom_range(0, 5));
        end
        press(s, k, $urandom_range(DC + 2, 15));
      end
    end

    tick(20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
